// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the multi-cycle MIPS-subset CPU. Each instruction is
// sequenced through INIT/IF/ID/EXE/MEM/WB. Errors (illegal opcode, DM address
// error, DM wait timeout) park the machine in HALT until reset. Retired
// instructions are counted.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   OpCode, func  instruction[31:26] / instruction[5:0] from the IR
//   zero          ALU zero flag (beq decision)
//   overflow      ALU signed overflow (suppresses addi write-back)
//   AddressError  DM misaligned / out-of-range access
//   mem_ready     DM access completes this cycle (sampled only in MEM)
//   PCWr, IRWr, RegWrite, MemWrite              write enables
//   nPC_sel, J, jal, jr, ALUSrc, RegDst, Mem_to_Reg   datapath selects
//   Extop         00 zero-ext, 01 sign-ext, 10 upper
//   ALUop         000 add, 001 sub, 010 or, 011 slt, 100 pass-imm
//   state         current state code
//   halted        high while in HALT
//   err_code      00 none, 01 illegal opcode, 10 address error, 11 timeout
//   instr_cnt     retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        overflow,
  input  logic        AddressError,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        nPC_sel,
  output logic        J,
  output logic        jal,
  output logic        jr,
  output logic        ALUSrc,
  output logic        RegDst,
  output logic        Mem_to_Reg,
  output logic [1:0]  Extop,
  output logic [2:0]  ALUop,
  output logic [3:0]  state,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_EXE  = 4'd3,
    S_MEM  = 4'd4,
    S_WB   = 4'd5,
    S_HALT = 4'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ADDR    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;

  logic is_r_s, is_addu_s, is_subu_s, is_slt_s, is_jr_s;
  logic is_addi_s, is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s;
  logic is_j_s, is_jal_s, legal_s;
  logic       alu_src_s;
  logic [1:0] ext_op_s;
  logic [2:0] alu_op_s;
  logic       retire_s;

  // Instruction decode from the (stable from ID onward) IR fields.
  always_comb begin
    is_r_s    = (OpCode == OP_RTYPE);
    is_addu_s = is_r_s && (func == FN_ADDU);
    is_subu_s = is_r_s && (func == FN_SUBU);
    is_slt_s  = is_r_s && (func == FN_SLT);
    is_jr_s   = is_r_s && (func == FN_JR);
    is_addi_s = (OpCode == OP_ADDI);
    is_ori_s  = (OpCode == OP_ORI);
    is_lui_s  = (OpCode == OP_LUI);
    is_lw_s   = (OpCode == OP_LW);
    is_sw_s   = (OpCode == OP_SW);
    is_beq_s  = (OpCode == OP_BEQ);
    is_j_s    = (OpCode == OP_J);
    is_jal_s  = (OpCode == OP_JAL);
    legal_s   = is_addu_s | is_subu_s | is_slt_s | is_jr_s | is_addi_s |
                is_ori_s | is_lui_s | is_lw_s | is_sw_s | is_beq_s |
                is_j_s | is_jal_s;
  end

  // Per-instruction ALU operation, operand select and immediate extension.
  always_comb begin
    alu_src_s = 1'b0;
    ext_op_s  = 2'b00;
    alu_op_s  = 3'b000;
    if (is_subu_s) begin
      alu_op_s = 3'b001;
    end else if (is_slt_s) begin
      alu_op_s = 3'b011;
    end else if (is_addi_s || is_lw_s || is_sw_s) begin
      alu_src_s = 1'b1;
      ext_op_s  = 2'b01;
      alu_op_s  = 3'b000;
    end else if (is_ori_s) begin
      alu_src_s = 1'b1;
      ext_op_s  = 2'b00;
      alu_op_s  = 3'b010;
    end else if (is_lui_s) begin
      alu_src_s = 1'b1;
      ext_op_s  = 2'b10;
      alu_op_s  = 3'b100;
    end else if (is_beq_s) begin
      ext_op_s  = 2'b01;
      alu_op_s  = 3'b001;
    end else begin
      alu_op_s  = 3'b000;
    end
  end

  // Next-state and control outputs; everything defaults to inactive.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    nPC_sel    = 1'b0;
    J          = 1'b0;
    jal        = 1'b0;
    jr         = 1'b0;
    ALUSrc     = 1'b0;
    RegDst     = 1'b0;
    Mem_to_Reg = 1'b0;
    Extop      = 2'b00;
    ALUop      = 3'b000;
    halted     = 1'b0;
    case (state_q)
      S_INIT: begin
        state_d = S_IF;
      end
      S_IF: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_j_s) begin
          PCWr    = 1'b1;
          J       = 1'b1;
          state_d = S_IF;
        end else if (is_jal_s) begin
          PCWr     = 1'b1;
          J        = 1'b1;
          jal      = 1'b1;
          RegWrite = 1'b1;
          state_d  = S_IF;
        end else if (is_jr_s) begin
          PCWr    = 1'b1;
          jr      = 1'b1;
          state_d = S_IF;
        end else if (legal_s) begin
          state_d = S_EXE;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EXE: begin
        ALUSrc = alu_src_s;
        Extop  = ext_op_s;
        ALUop  = alu_op_s;
        if (is_beq_s) begin
          nPC_sel = 1'b1;
          PCWr    = zero;
          state_d = S_IF;
        end else if (is_lw_s || is_sw_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Address operands stay on the ALU for the whole access.
        ALUSrc = alu_src_s;
        Extop  = ext_op_s;
        ALUop  = alu_op_s;
        // AddressError outranks completion; timeout fires once the allowed
        // number of wait cycles has been spent, with the store withdrawn.
        if (AddressError) begin
          state_d = S_HALT;
          err_d   = ERR_ADDR;
        end else if (wait_q >= TIMEOUT_C) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end else if (mem_ready) begin
          MemWrite = is_sw_s;
          state_d  = is_sw_s ? S_IF : S_WB;
        end else begin
          MemWrite = is_sw_s;
          state_d  = S_MEM;
        end
      end
      S_WB: begin
        RegWrite   = !(is_addi_s && overflow);
        RegDst     = is_r_s;
        Mem_to_Reg = is_lw_s;
        state_d    = S_IF;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Wait counter is zero outside MEM so every MEM entry starts from zero.
  always_comb begin
    wait_d = wait_q;
    if (state_q != S_MEM) begin
      wait_d = 8'd0;
    end else if (!mem_ready && (wait_q != 8'hFF)) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // An instruction retires on any return to IF except the one out of INIT.
  always_comb begin
    retire_s = (state_d == S_IF) &&
               ((state_q == S_ID) || (state_q == S_EXE) ||
                (state_q == S_MEM) || (state_q == S_WB));
    if (retire_s) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, error, wait and retire registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      err_q   <= ERR_NONE;
      cnt_q   <= 32'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign state     = state_q;
  assign err_code  = err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each driven cycle pushes its
// hand-computed expected controller outputs into a scoreboard queue; an
// independent monitor pops one entry per falling edge and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [3:0] ST_INIT = 4'd0;
  localparam logic [3:0] ST_IF   = 4'd1;
  localparam logic [3:0] ST_ID   = 4'd2;
  localparam logic [3:0] ST_EXE  = 4'd3;
  localparam logic [3:0] ST_MEM  = 4'd4;
  localparam logic [3:0] ST_WB   = 4'd5;
  localparam logic [3:0] ST_HALT = 4'd7;

  // control vector: PCWr IRWr RegWrite MemWrite nPC_sel J jal jr RegDst Mem_to_Reg
  localparam logic [9:0] C_PC  = 10'b10_0000_0000;
  localparam logic [9:0] C_IR  = 10'b01_0000_0000;
  localparam logic [9:0] C_RW  = 10'b00_1000_0000;
  localparam logic [9:0] C_MW  = 10'b00_0100_0000;
  localparam logic [9:0] C_NS  = 10'b00_0010_0000;
  localparam logic [9:0] C_J   = 10'b00_0001_0000;
  localparam logic [9:0] C_JL  = 10'b00_0000_1000;
  localparam logic [9:0] C_JR  = 10'b00_0000_0100;
  localparam logic [9:0] C_RD  = 10'b00_0000_0010;
  localparam logic [9:0] C_M2R = 10'b00_0000_0001;
  localparam logic [9:0] C_0   = 10'b00_0000_0000;

  typedef struct packed {
    logic [3:0]  st;
    logic [9:0]  ctrl;
    logic [1:0]  chk;   // [1] check ALUSrc/ALUop, [0] check Extop
    logic [5:0]  alu;   // {ALUSrc, Extop[1:0], ALUop[2:0]}
    logic        hlt;
    logic [1:0]  err;
    logic [31:0] cnt;
  } exp_t;

  logic clk, reset;
  logic [5:0] OpCode, func;
  logic zero, overflow, AddressError, mem_ready;
  logic PCWr, IRWr, RegWrite, MemWrite, nPC_sel, J, jal, jr;
  logic ALUSrc, RegDst, Mem_to_Reg, halted;
  logic [1:0] Extop, err_code;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic [31:0] instr_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    test_cnt = 0;
  int    fail_cnt = 0;

  multicycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .func(func), .zero(zero),
    .overflow(overflow), .AddressError(AddressError), .mem_ready(mem_ready),
    .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .nPC_sel(nPC_sel), .J(J), .jal(jal), .jr(jr), .ALUSrc(ALUSrc),
    .RegDst(RegDst), .Mem_to_Reg(Mem_to_Reg), .Extop(Extop), .ALUop(ALUop),
    .state(state), .halted(halted), .err_code(err_code), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic step(input string nm, input logic [3:0] st, input logic [9:0] c,
                      input logic [1:0] chk, input logic [5:0] alu,
                      input logic [1:0] er, input logic [31:0] cnt);
    exp_t e;
    e.st = st; e.ctrl = c; e.chk = chk; e.alu = alu;
    e.hlt = (st == ST_HALT); e.err = er; e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic  ok;
      logic [9:0] act;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {PCWr, IRWr, RegWrite, MemWrite, nPC_sel, J, jal, jr, RegDst, Mem_to_Reg};
      ok  = (state == e.st) && (act == e.ctrl) && (halted == e.hlt) &&
            (err_code == e.err) && (instr_cnt == e.cnt) &&
            (!e.chk[1] || ({ALUSrc, ALUop} == {e.alu[5], e.alu[2:0]})) &&
            (!e.chk[0] || (Extop == e.alu[4:3]));
      test_cnt++;
      if (!ok) begin
        fail_cnt++;
        $display("FAIL %s: got st=%0d ctrl=%b src=%b ext=%b op=%b hlt=%b err=%b cnt=%0d; want st=%0d ctrl=%b alu=%b(chk %b) hlt=%b err=%b cnt=%0d",
                 nm, state, act, ALUSrc, Extop, ALUop, halted, err_code, instr_cnt,
                 e.st, e.ctrl, e.alu, e.chk, e.hlt, e.err, e.cnt);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    step("rst", ST_INIT, C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    reset = 1'b1;
    step("init", ST_INIT, C_0, 2'b00, 6'd0, 2'b00, 32'd0);
  endtask

  initial begin
    reset = 1'b0; OpCode = 6'd0; func = 6'd0; zero = 1'b0; overflow = 1'b0;
    AddressError = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step("rst0", ST_INIT, C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    do_reset();

    // addu: 0,1,2,3,5,1
    OpCode = 6'b000000; func = 6'b100001;
    step("addu_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd0);
    step("addu_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    step("addu_exe", ST_EXE, C_0, 2'b10, {1'b0, 2'b00, 3'b000}, 2'b00, 32'd0);
    step("addu_wb",  ST_WB,  C_RW | C_RD, 2'b00, 6'd0, 2'b00, 32'd0);

    // lw with three wait cycles: CPI 8
    OpCode = 6'b100011;
    step("lw_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd1);
    step("lw_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd1);
    step("lw_exe", ST_EXE, C_0, 2'b11, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", ST_MEM, C_0, 2'b10, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd1);
    mem_ready = 1'b1;
    step("lw_mem_rdy", ST_MEM, C_0, 2'b10, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd1);
    step("lw_wb",      ST_WB,  C_RW | C_M2R, 2'b00, 6'd0, 2'b00, 32'd1);

    // beq taken, then not taken
    OpCode = 6'b000100; zero = 1'b1;
    step("beqT_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd2);
    step("beqT_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd2);
    step("beqT_exe", ST_EXE, C_PC | C_NS, 2'b11, {1'b0, 2'b01, 3'b001}, 2'b00, 32'd2);
    zero = 1'b0;
    step("beqN_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd3);
    step("beqN_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd3);
    step("beqN_exe", ST_EXE, C_NS, 2'b11, {1'b0, 2'b01, 3'b001}, 2'b00, 32'd3);

    // jal, j, jr
    OpCode = 6'b000011;
    step("jal_if", ST_IF, C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd4);
    step("jal_id", ST_ID, C_PC | C_J | C_JL | C_RW, 2'b00, 6'd0, 2'b00, 32'd4);
    OpCode = 6'b000010;
    step("j_if",   ST_IF, C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd5);
    step("j_id",   ST_ID, C_PC | C_J, 2'b00, 6'd0, 2'b00, 32'd5);
    OpCode = 6'b000000; func = 6'b001000;
    step("jr_if",  ST_IF, C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd6);
    step("jr_id",  ST_ID, C_PC | C_JR, 2'b00, 6'd0, 2'b00, 32'd6);

    // addi with overflow: no register write, still retires
    OpCode = 6'b001000; overflow = 1'b1;
    step("addi_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd7);
    step("addi_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd7);
    step("addi_exe", ST_EXE, C_0, 2'b11, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd7);
    step("addi_wb",  ST_WB,  C_0, 2'b00, 6'd0, 2'b00, 32'd7);
    overflow = 1'b0;

    // lui, ori
    OpCode = 6'b001111;
    step("lui_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd8);
    step("lui_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd8);
    step("lui_exe", ST_EXE, C_0, 2'b11, {1'b1, 2'b10, 3'b100}, 2'b00, 32'd8);
    step("lui_wb",  ST_WB,  C_RW, 2'b00, 6'd0, 2'b00, 32'd8);
    OpCode = 6'b001101;
    step("ori_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd9);
    step("ori_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd9);
    step("ori_exe", ST_EXE, C_0, 2'b11, {1'b1, 2'b00, 3'b010}, 2'b00, 32'd9);
    step("ori_wb",  ST_WB,  C_RW, 2'b00, 6'd0, 2'b00, 32'd9);

    // sw with immediate completion: 4 cycles
    OpCode = 6'b101011;
    step("sw_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd10);
    step("sw_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd10);
    step("sw_exe", ST_EXE, C_0, 2'b11, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd10);
    step("sw_mem", ST_MEM, C_MW, 2'b10, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd10);

    // subu, slt
    OpCode = 6'b000000; func = 6'b100011;
    step("subu_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd11);
    step("subu_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd11);
    step("subu_exe", ST_EXE, C_0, 2'b10, {1'b0, 2'b00, 3'b001}, 2'b00, 32'd11);
    step("subu_wb",  ST_WB,  C_RW | C_RD, 2'b00, 6'd0, 2'b00, 32'd11);
    func = 6'b101010;
    step("slt_if",   ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd12);
    step("slt_id",   ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd12);
    step("slt_exe",  ST_EXE, C_0, 2'b10, {1'b0, 2'b00, 3'b011}, 2'b00, 32'd12);
    step("slt_wb",   ST_WB,  C_RW | C_RD, 2'b00, 6'd0, 2'b00, 32'd12);

    // illegal opcode: HALT, enables quiet for 10 cycles, mem_ready ignored
    OpCode = 6'b111111;
    step("ill_if", ST_IF, C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd13);
    step("ill_id", ST_ID, C_0, 2'b00, 6'd0, 2'b00, 32'd13);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      step("ill_halt", ST_HALT, C_0, 2'b00, 6'd0, 2'b01, 32'd13);
    end
    mem_ready = 1'b1;
    do_reset();

    // illegal func under R-type
    OpCode = 6'b000000; func = 6'b000001;
    step("illf_if", ST_IF, C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd0);
    step("illf_id", ST_ID, C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    step("illf_halt", ST_HALT, C_0, 2'b00, 6'd0, 2'b01, 32'd0);
    do_reset();

    // sw timeout: 15 waiting cycles with MemWrite, then withdrawn and HALT
    OpCode = 6'b101011; mem_ready = 1'b0;
    step("swto_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd0);
    step("swto_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    step("swto_exe", ST_EXE, C_0, 2'b11, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd0);
    for (int i = 0; i < 15; i++)
      step("swto_wait", ST_MEM, C_MW, 2'b10, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd0);
    step("swto_last", ST_MEM, C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    step("swto_halt", ST_HALT, C_0, 2'b00, 6'd0, 2'b11, 32'd0);
    mem_ready = 1'b1;
    step("swto_halt2", ST_HALT, C_0, 2'b00, 6'd0, 2'b11, 32'd0);
    do_reset();

    // sw address error wins over mem_ready
    step("swae_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd0);
    step("swae_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    step("swae_exe", ST_EXE, C_0, 2'b11, {1'b1, 2'b01, 3'b000}, 2'b00, 32'd0);
    AddressError = 1'b1;
    step("swae_mem", ST_MEM, C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    AddressError = 1'b0;
    step("swae_halt", ST_HALT, C_0, 2'b00, 6'd0, 2'b10, 32'd0);
    do_reset();

    // reset mid-instruction: aborted in EXE, back to INIT at once
    OpCode = 6'b000000; func = 6'b100001;
    step("mid_if",  ST_IF,  C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd0);
    step("mid_id",  ST_ID,  C_0, 2'b00, 6'd0, 2'b00, 32'd0);
    do_reset();
    step("mid_if2", ST_IF, C_PC | C_IR, 2'b00, 6'd0, 2'b00, 32'd0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      fail_cnt++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state control unit for the multi-cycle MIPS-subset CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every enable and select consumed by the ifu, RegFile, ALU, Extender and DM datapath blocks. It also handles data-memory wait states, a memory-wait timeout, illegal opcodes and address errors by halting, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 15: maximum `mem_ready` wait cycles in MEM before a timeout halt (1..255).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- OpCode  in  6  instruction[31:26], from GetCode on the instruction register.
- func  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed overflow.
- AddressError  in  1  DM address-misaligned/out-of-range flag.
- mem_ready  in  1  DM access complete this cycle.
- PCWr, IRWr, RegWrite, MemWrite  out  1 each  write enables.
- nPC_sel, J, jal, jr, ALUSrc, RegDst, Mem_to_Reg  out  1 each  datapath selects.
- Extop  out  2  00 zero-ext, 01 sign-ext, 10 upper (imm<<16).
- ALUop  out  3  000 add, 001 sub, 010 or, 011 slt, 100 pass-imm.
- state  out  4  current state code.
- halted  out  1  high in HALT.
- err_code  out  2  00 none, 01 illegal opcode, 10 address error, 11 mem timeout.
- instr_cnt  out  32  retired-instruction count.

## Operation
- Supported instructions:
  - R-type (OpCode 000000): addu 100001, subu 100011, slt 101010, jr 001000.
  - I-type: addi 001000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100.
  - J-type: j 000010, jal 000011.
- States: INIT 0, IF 1, ID 2, EXE 3, MEM 4, WB 5, HALT 7. Codes 6 and 8–15 are unreachable; if ever entered, next state is HALT.
- INIT: all enables 0 → IF.
- IF: IRWr=1, PCWr=1 (PC+4 path; nPC_sel=J=jal=jr=0) → ID.
- ID transitions:
  - j: PCWr=1, J=1 → IF.
  - jal: PCWr=1, J=1, jal=1, RegWrite=1 → IF.
  - jr: PCWr=1, jr=1 → IF.
  - Other legal opcodes → EXE.
  - Illegal OpCode, or illegal func under OpCode 000000 → HALT, err_code=01.
- EXE:
  - ALUop and ALUSrc are driven per instruction; Extop is 01 for addi/lw/sw/beq, 00 for ori, 10 for lui.
  - beq: ALUop=001, nPC_sel=1, PCWr=zero → IF.
  - lw/sw: ALUop=000, ALUSrc=1 → MEM.
  - All others → WB.
- MEM: ALUSrc/ALUop are held from EXE.
  - If AddressError: MemWrite=0 → HALT, err_code=10.
  - sw: MemWrite=1 while waiting; on mem_ready → IF.
  - lw: on mem_ready → WB.
  - Wait counter (8-bit) clears on MEM entry and increments each cycle without mem_ready. On reaching MEM_TIMEOUT → HALT, err_code=11, MemWrite=0 in that cycle.
- WB: RegWrite=1; RegDst=1 for R-type; Mem_to_Reg=1 for lw. For addi with overflow=1, RegWrite=0 (instruction still retires). → IF.
- HALT: all enables 0; halted=1; err_code is held. Only reset exits.
- Enables and selects are combinational (Moore-plus-opcode) from state, OpCode and func. OpCode/func are stable from ID onward because IRWr is asserted only in IF.
- instr_cnt increments by 1 on each transition into IF from ID, EXE, MEM or WB (retire). It wraps 0xFFFFFFFF→0. It does not increment on INIT→IF.

## Timing
- On reset assertion (async): state=INIT, all enables 0, halted=0, err_code=00, instr_cnt=0, wait counter=0.
- After reset deassertion, the first rising edge moves to IF, so the first fetch occurs in the 2nd cycle after release.
- Cycles per instruction with mem_ready held high:
  - j/jal/jr: 2.
  - beq: 3.
  - R-type, addi, ori, lui: 4.
  - sw: 4.
  - lw: 5.
  - Each mem_ready-low cycle in MEM adds 1.
- mem_ready is sampled only in MEM; it is ignored in other states.
- When AddressError and mem_ready are high in the same MEM cycle, AddressError wins (→ HALT).
- A reset asserted mid-instruction aborts it immediately, with no write enable beyond that edge.

## Test plan
- Reset, then addu with mem_ready=1 → state sequence 0,1,2,3,5,1; RegWrite=1 only in WB with RegDst=1; instr_cnt=1.
- lw with mem_ready low for 3 MEM cycles → 3 extra MEM cycles, then WB with Mem_to_Reg=1; CPI 8.
- beq with zero=1, then beq with zero=0 → PCWr=1 with nPC_sel=1 in EXE only for the first; both take 3 cycles.
- jal → in ID, PCWr=J=jal=RegWrite=1; back in IF the next cycle; instr_cnt increments.
- OpCode 111111 → HALT with err_code=01 and halted=1; all enables stay 0 for 10 cycles; reset returns to INIT.
- sw with mem_ready held low, MEM_TIMEOUT=15 → 15 MEM cycles with MemWrite=1, then HALT with err_code=11. Repeat with AddressError=1 → immediate HALT, err_code=10, MemWrite=0.
